// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the ALU issue/writeback slice: opcode
//               encodings, illegal-opcode boundary, FSM state encoding, flag
//               bit positions and conditional-execution codes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    // Register file geometry
    localparam int NREGS  = 4;
    localparam int REG_AW = $clog2(NREGS);

    // ALU opcodes implemented by the downstream combinational ALU
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_INC = 4'b0010;
    localparam logic [3:0] OP_DEC = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b0110;
    localparam logic [3:0] OP_NOT = 4'b0111;
    localparam logic [3:0] OP_SHL = 4'b1000;
    localparam logic [3:0] OP_SHR = 4'b1001;
    localparam logic [3:0] OP_ROL = 4'b1010;
    localparam logic [3:0] OP_ROR = 4'b1011;

    // Lowest illegal opcode value
    localparam logic [3:0] ILLEGAL_BASE = 4'b1100;

    // Issue FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    // Bit positions inside the {Z,C,V,S} flags vector
    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_S = 0;

    // Conditional-execution codes
    localparam logic [1:0] COND_ALWAYS = 2'b00;
    localparam logic [1:0] COND_Z      = 2'b01;
    localparam logic [1:0] COND_C      = 2'b10;
    localparam logic [1:0] COND_NZ     = 2'b11;

endpackage : alu_pkg

`default_nettype wire

// File: rtl/alu_issue_regfile.sv
// ============================================================================
// Module      : alu_issue_regfile
// Description : NREGS x 8-bit register file with two combinational operand
//               read ports, one combinational debug read port and one
//               synchronous write port. Synchronous active-high reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue_regfile #(
    parameter int NREGS = 4,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr1,
    output logic [7:0]    o_rdata1,
    input  logic [AW-1:0] i_raddr2,
    output logic [7:0]    o_rdata2,
    input  logic [AW-1:0] i_dbg_addr,
    output logic [7:0]    o_dbg_data
);

    logic [7:0] r_mem [NREGS];

    // Storage update: clear everything on reset, otherwise single write port
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Reads return current (pre-write) contents, so same-edge writes are not bypassed
    always_comb begin
        o_rdata1   = r_mem[i_raddr1];
        o_rdata2   = r_mem[i_raddr2];
        o_dbg_data = r_mem[i_dbg_addr];
    end

endmodule : alu_issue_regfile

`default_nettype wire

// File: rtl/alu_issue_unit.sv
// ============================================================================
// Module      : alu_issue_unit
// Description : Issue/writeback stage in front of the 8-bit combinational
//               ALU. Accepts micro-ops over valid/ready, registers operands
//               into the ALU inputs, and commits result and flags back.
//               Optional feature macro: ALU_ISSUE_CONDEXEC_EN (adds in_cond
//               and wb_skip for flag-conditioned execution).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue_unit
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_opcode,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic              in_use_imm,
    input  logic [7:0]        in_imm,
    output logic [3:0]        alu_opcode,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    input  logic [7:0]        alu_result,
    input  logic              alu_zero,
    input  logic              alu_carry,
    input  logic              alu_overflow,
    input  logic              alu_sign,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_rd,
    output logic [7:0]        wb_data,
    output logic [3:0]        flags,
    output logic              err,
`ifdef ALU_ISSUE_CONDEXEC_EN
    input  logic [1:0]        in_cond,
    output logic              wb_skip,
`endif
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [7:0]        dbg_data
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [REG_AW-1:0] r_rd;
    logic              w_xfer;
    logic              w_illegal;
    logic              w_cond_ok;
    logic              w_rf_we;
    logic [3:0]        w_flags_new;
    logic [7:0]        w_rs1_data;
    logic [7:0]        w_rs2_data;
`ifdef ALU_ISSUE_CONDEXEC_EN
    logic [1:0]        r_cond;
`endif

    alu_issue_regfile #(
        .NREGS (NREGS),
        .AW    (REG_AW)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .i_we       (w_rf_we),
        .i_waddr    (r_rd),
        .i_wdata    (alu_result),
        .i_raddr1   (in_rs1),
        .o_rdata1   (w_rs1_data),
        .i_raddr2   (in_rs2),
        .o_rdata2   (w_rs2_data),
        .i_dbg_addr (dbg_addr),
        .o_dbg_data (dbg_data)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, handshake and commit qualification
    always_comb begin
        w_state_nxt = ST_IDLE;
        in_ready    = 1'b0;
        case (r_state)
            ST_IDLE, ST_WB: begin
                in_ready    = 1'b1;
                w_state_nxt = in_valid ? ST_EXEC : ST_IDLE;
            end
            ST_EXEC: begin
                w_state_nxt = ST_WB;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_xfer    = in_valid && in_ready;
        w_illegal = (alu_opcode >= ILLEGAL_BASE);

        // Conditions look at flags as they stand before this op updates them
        w_cond_ok = 1'b1;
`ifdef ALU_ISSUE_CONDEXEC_EN
        case (r_cond)
            COND_ALWAYS: w_cond_ok = 1'b1;
            COND_Z:      w_cond_ok = flags[FLAG_Z];
            COND_C:      w_cond_ok = flags[FLAG_C];
            COND_NZ:     w_cond_ok = !flags[FLAG_Z];
            default:     w_cond_ok = 1'b1;
        endcase
`endif
        w_rf_we = (r_state == ST_EXEC) && !w_illegal && w_cond_ok;

        w_flags_new         = 4'h0;
        w_flags_new[FLAG_Z] = alu_zero;
        w_flags_new[FLAG_C] = alu_carry;
        w_flags_new[FLAG_V] = alu_overflow;
        w_flags_new[FLAG_S] = alu_sign;
    end

    // Operand capture at transfer; result/flag commit at the EXEC->WB edge
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_opcode <= 4'h0;
            alu_a      <= 8'h00;
            alu_b      <= 8'h00;
            r_rd       <= '0;
            wb_valid   <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= 8'h00;
            flags      <= 4'h0;
            err        <= 1'b0;
`ifdef ALU_ISSUE_CONDEXEC_EN
            r_cond     <= COND_ALWAYS;
            wb_skip    <= 1'b0;
`endif
        end else begin
            wb_valid <= 1'b0;
`ifdef ALU_ISSUE_CONDEXEC_EN
            wb_skip  <= 1'b0;
`endif
            if (w_xfer) begin
                alu_opcode <= in_opcode;
                alu_a      <= w_rs1_data;
                alu_b      <= in_use_imm ? in_imm : w_rs2_data;
                r_rd       <= in_rd;
`ifdef ALU_ISSUE_CONDEXEC_EN
                r_cond     <= in_cond;
`endif
            end
            if (r_state == ST_EXEC) begin
                if (w_illegal) begin
                    err <= 1'b1;
                end else if (w_cond_ok) begin
                    wb_valid <= 1'b1;
                    wb_rd    <= r_rd;
                    wb_data  <= alu_result;
                    flags    <= w_flags_new;
                end else begin
`ifdef ALU_ISSUE_CONDEXEC_EN
                    wb_skip  <= 1'b1;
`endif
                end
            end
        end
    end

endmodule : alu_issue_unit

`default_nettype wire
